// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
//
// Collects rising edges on N_SRC peripheral interrupt lines into a pending
// register, qualifies them with a software-writable enable mask and presents
// the highest-priority (lowest index) enabled source to the CPU on INT_irq.
// A request / acknowledge / end-of-interrupt handshake hands the source over
// to the CPU's interrupt-entry sequence; the source ID and its handler vector
// are held for the whole handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   irq_src     interrupt request lines (edge detected, synchronous to clk)
//   mask_we     mask write strobe
//   mask_wdata  new enable mask, bit=1 enables the source
//   INTA_irq    CPU acknowledge pulse (honoured only while requesting)
//   eoi         CPU end-of-interrupt pulse (honoured only while in service)
//   INT_irq     registered interrupt request to the CPU
//   int_id      ID of the requested / in-service source
//   int_vec     handler address VEC_BASE + int_id*4 (32-bit wrap)
//   mask        current enable mask
//   pending     current pending register
//   in_service  high while the CPU services an acknowledged interrupt
//   state       FSM state, for debug (IDLE=0, REQ=1, SERVICE=2)
// -----------------------------------------------------------------------------
module irq_arbiter #(
    parameter int          N_SRC    = 8,
    parameter int          ID_W     = 3,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wdata,
    input  logic              INTA_irq,
    input  logic              eoi,
    output logic              INT_irq,
    output logic [ID_W-1:0]   int_id,
    output logic [31:0]       int_vec,
    output logic [N_SRC-1:0]  mask,
    output logic [N_SRC-1:0]  pending,
    output logic              in_service,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               int_irq_q, int_irq_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic               in_service_q, in_service_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   irq_prev_q;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   enabled;
    logic [N_SRC-1:0]   id_onehot;
    logic [N_SRC-1:0]   clr;
    logic               win_any;
    logic [ID_W-1:0]    win_id;
    logic               latched_live;

    // History resets to 0, so a line already high at reset release counts
    // as one edge.
    assign rise    = irq_src & ~irq_prev_q;
    assign enabled = pending_q & mask_q;

    // One-hot view of the latched ID; avoids out-of-range bit selects when
    // 2**ID_W exceeds N_SRC.
    assign id_onehot    = N_SRC'(1) << int_id_q;
    assign latched_live = |(enabled & id_onehot);

    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        win_id  = '0;
        win_any = |enabled;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        int_irq_d    = int_irq_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;
        clr          = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    int_id_d  = win_id;
                    int_irq_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end

            // No preemption: int_id stays put until the CPU acknowledges
            // or the latched source stops being enabled-and-pending.
            ST_REQ: begin
                if (INTA_irq) begin
                    clr          = id_onehot;
                    int_irq_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end else if (!latched_live) begin
                    int_irq_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            ST_SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                int_irq_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        // A new edge landing in the same cycle as its acknowledge survives.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            int_irq_q    <= 1'b0;
            int_id_q     <= '0;
            in_service_q <= 1'b0;
            mask_q       <= '0;
            pending_q    <= '0;
            irq_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            int_irq_q    <= int_irq_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_src;
        end
    end

    assign INT_irq    = int_irq_q;
    assign int_id     = int_id_q;
    assign int_vec    = VEC_BASE + (32'(int_id_q) << 2);
    assign mask       = mask_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign state      = state_q;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

    localparam int          N    = 8;
    localparam int          IDW  = 3;
    localparam logic [31:0] VB   = 32'h0000_0100;

    logic           clk;
    logic           rst;
    logic [N-1:0]   irq_src;
    logic           mask_we;
    logic [N-1:0]   mask_wdata;
    logic           INTA_irq;
    logic           eoi;
    logic           INT_irq;
    logic [IDW-1:0] int_id;
    logic [31:0]    int_vec;
    logic [N-1:0]   mask;
    logic [N-1:0]   pending;
    logic           in_service;
    logic [1:0]     state;

    irq_arbiter #(.N_SRC(N), .ID_W(IDW), .VEC_BASE(VB)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .INTA_irq   (INTA_irq),
        .eoi        (eoi),
        .INT_irq    (INT_irq),
        .int_id     (int_id),
        .int_vec    (int_vec),
        .mask       (mask),
        .pending    (pending),
        .in_service (in_service),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the arbiter as a transaction-level description.
    // phase: 0 idle, 1 requesting, 2 in service.
    logic [N-1:0] m_pend, m_mask, m_prev;
    int           m_phase;
    int           m_id;
    logic         m_int;
    logic         m_svc;

    function automatic int lowest_set(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_phase = 0; m_id = 0; m_int = 1'b0; m_svc = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] newly;
        logic [N-1:0] served;
        newly  = irq_src & ~m_prev;
        served = '0;
        if (m_phase == 0) begin
            if ((m_pend & m_mask) != 0) begin
                m_id    = lowest_set(m_pend & m_mask);
                m_int   = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (INTA_irq) begin
                served[m_id] = 1'b1;
                m_int   = 1'b0;
                m_svc   = 1'b1;
                m_phase = 2;
            end else if (!(m_pend[m_id] && m_mask[m_id])) begin
                m_int   = 1'b0;
                m_phase = 0;
            end
        end else begin
            if (eoi) begin
                m_svc   = 1'b0;
                m_phase = 0;
            end
        end
        m_pend = (m_pend & ~served) | newly;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_src;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",      32'(state),      32'(m_phase));
        chk("INT_irq",    32'(INT_irq),    32'(m_int));
        chk("int_id",     32'(int_id),     32'(m_id));
        chk("int_vec",    int_vec,         VB + 32'(m_id) * 4);
        chk("mask",       32'(mask),       32'(m_mask));
        chk("pending",    32'(pending),    32'(m_pend));
        chk("in_service", 32'(in_service), 32'(m_svc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse_src(input int idx);
        irq_src[idx] = 1'b1; step(); irq_src[idx] = 1'b0;
    endtask

    task automatic ack();
        INTA_irq = 1'b1; step(); INTA_irq = 1'b0;
    endtask

    task automatic end_int();
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we = 1'b1; mask_wdata = v; step(); mask_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
        INTA_irq = 1'b0; eoi = 1'b0;
        model_reset();
        #22;
        check_all();
        chk("reset_vec", int_vec, 32'h0000_0100);
        @(negedge clk);
        rst = 1'b0;

        // Single source
        write_mask(8'h04);
        pulse_src(2);
        chk("t1_pend", 32'(pending), 32'h04);
        step();
        chk("t1_int", 32'(INT_irq), 32'd1);
        chk("t1_id", 32'(int_id), 32'd2);
        chk("t1_vec", int_vec, 32'h108);
        ack();
        chk("t1_pend_clr", 32'(pending), 32'h00);
        chk("t1_svc", 32'(in_service), 32'd1);
        step();
        end_int();
        chk("t1_idle", 32'(state), 32'd0);
        step();
        chk("t1_int_low", 32'(INT_irq), 32'd0);

        // Priority
        write_mask(8'hFF);
        irq_src = 8'h22; step(); irq_src = '0;
        step();
        chk("t2_id1", 32'(int_id), 32'd1);
        ack();
        end_int();
        step();
        chk("t2_id5", 32'(int_id), 32'd5);
        chk("t2_int", 32'(INT_irq), 32'd1);
        ack();
        end_int();

        // No preemption
        pulse_src(4);
        step();
        pulse_src(0);
        step();
        chk("t3_hold4", 32'(int_id), 32'd4);
        ack();
        end_int();
        step();
        chk("t3_then0", 32'(int_id), 32'd0);
        ack();
        end_int();

        // Mask withdrawal
        pulse_src(3);
        step();
        write_mask(8'h00);
        step();
        chk("t4_int_low", 32'(INT_irq), 32'd0);
        chk("t4_idle", 32'(state), 32'd0);
        chk("t4_pend3", 32'(pending[3]), 32'd1);
        write_mask(8'hFF);
        step();
        chk("t4_rereq", 32'(INT_irq), 32'd1);
        chk("t4_id3", 32'(int_id), 32'd3);
        ack();
        end_int();

        // Set/clear collision
        pulse_src(6);
        step();
        irq_src[6] = 1'b1; INTA_irq = 1'b1; step(); irq_src[6] = 1'b0; INTA_irq = 1'b0;
        chk("t5_pend6", 32'(pending[6]), 32'd1);
        chk("t5_svc", 32'(state), 32'd2);
        end_int();
        step();
        chk("t5_rereq", 32'(int_id), 32'd6);
        chk("t5_int", 32'(INT_irq), 32'd1);
        ack();

        // Async reset while in service
        chk("t6_pre", 32'(state), 32'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_vec", int_vec, 32'h100);
        @(negedge clk);
        rst = 1'b0;
        INTA_irq = 1'b1; eoi = 1'b1; step(); INTA_irq = 1'b0; eoi = 1'b0;
        step();
        chk("t6_stray_state", 32'(state), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            irq_src    = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            mask_we    = ($urandom_range(0, 9) == 0);
            mask_wdata = N'($urandom);
            INTA_irq   = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            eoi        = ($urandom_range(0, 3) == 0);
            step();
        end
        irq_src = '0; mask_we = 1'b0; INTA_irq = 1'b0; eoi = 1'b0;

        // Source held high across reset release pends exactly once
        irq_src = 8'h80;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t7_held", 32'(pending), 32'h80);
        write_mask(8'h80);
        step();
        ack();
        step();
        chk("t7_no_repend", 32'(pending), 32'h00);
        end_int();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Interrupt arbiter placed between peripheral interrupt sources and the multi-cycle CPU controller. It latches rising edges on N request lines into a pending register and applies a software-writable enable mask. It selects the highest-priority enabled pending source and drives the single CPU-side INT_irq line. It completes a request/acknowledge/end-of-interrupt handshake with the CPU interrupt-entry sequence and supplies the source ID and handler vector address.

Parameters:
N_SRC, 8, number of interrupt sources (2..16)
ID_W, 3, width of source ID; must satisfy 2**ID_W >= N_SRC
VEC_BASE, 32'h0000_0100, vector address of source 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
irq_src  in  N_SRC  interrupt request lines, synchronous to clk, edge-detected
mask_we  in  1  mask write strobe
mask_wdata  in  N_SRC  new enable mask; bit=1 enables source
INTA_irq  in  1  CPU acknowledge pulse, 1 cycle
eoi  in  1  end-of-interrupt pulse from CPU, 1 cycle
INT_irq  out  1  interrupt request to CPU, registered
int_id  out  ID_W  ID of the requested/in-service source
int_vec  out  32  handler address = VEC_BASE + int_id*4, 32-bit wrap
mask  out  N_SRC  current enable mask
pending  out  N_SRC  current pending register
in_service  out  1  high while the CPU is servicing an acknowledged interrupt
state  out  2  FSM state encoding, for debug

Behaviour:
- Reset (async, any time, including mid-handshake): state=IDLE, INT_irq=0, int_id=0, mask=0, pending=0, in_service=0, edge-detect history=0, and int_vec therefore equals VEC_BASE. A source held high at reset release sets its pending bit once.
- Edge detect: pending[i] is set at clk edge k when irq_src[i]=1 at edge k and irq_src[i]=0 at edge k-1. Level-high without a new edge does not re-pend.
- Mask: when mask_we=1, mask <= mask_wdata at that edge. Masking never clears pending bits.
- Priority is fixed: the lowest index has the highest priority. The selection uses pending & mask.
- FSM encoding: IDLE=0, REQ=1, SERVICE=2. Encoding 3 is illegal and recovers to IDLE.
- IDLE: if (pending & mask) != 0, latch int_id = winner, set INT_irq=1, and go to REQ. Otherwise stay in IDLE.
- REQ: INT_irq held at 1 and int_id held stable. There is no preemption: a higher-priority arrival does not change int_id.
  - INTA_irq=1: clear pending[int_id], INT_irq<=0, in_service<=1, go to SERVICE.
  - Else if the latched source is no longer enabled and pending (for example because mask was written): INT_irq<=0, go to IDLE. A new arbitration starts on the next cycle.
- SERVICE: int_id held. On eoi=1: in_service<=0, go to IDLE. New pending edges still accumulate. There is no nesting.
- Ignored inputs: INTA_irq in IDLE or SERVICE; eoi in IDLE or REQ.
- Simultaneous set and clear of the same pending bit (new edge in the same cycle as its INTA): set wins, so the bit stays pending.
- Latency: a source edge at clk edge k sets pending at k. With the source enabled, INT_irq is high after edge k+1. After eoi at edge m, the next request can be asserted after edge m+1.
- int_vec is combinational from int_id only.

Test Plan:
- Single source: mask=8'h04, pulse irq_src[2] at edge k -> pending=8'h04 after k, INT_irq=1 and int_id=2 after k+1, int_vec=32'h108. INTA -> pending=0, in_service=1. eoi -> state=IDLE, INT_irq stays 0.
- Priority: mask=8'hFF, edges on sources 5 and 1 in the same cycle -> int_id=1. After INTA+eoi -> int_id=5 two cycles after eoi.
- No preemption: in REQ for source 4, edge on source 0 -> int_id stays 4 until INTA. Source 0 is served after the eoi.
- Mask withdrawal: in REQ for source 3, write mask=0 -> INT_irq=0 next cycle, state=IDLE, pending[3] still 1. Re-enable -> request reasserted.
- Set/clear collision: new edge on source 6 in the same cycle as its INTA -> pending[6]=1 after the edge, and it is re-requested after eoi.
- Async reset in SERVICE: assert rst mid-cycle -> all outputs at reset values immediately, without a clock edge. Stray INTA/eoi after reset produce no change.
